// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS run monitor: FSM states, verdict codes and the
// checkpoint-table entry layout.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] STAT_RUN      = 2'b00;
  localparam logic [1:0] STAT_PASS     = 2'b01;
  localparam logic [1:0] STAT_MISMATCH = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT  = 2'b11;

  // Entries carry the widest supported bus; narrower monitors zero-extend.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic             en;
    logic [MAX_W-1:0] adr;
    logic [MAX_W-1:0] dat;
  } chan_entry_t;

endpackage

// File: rtl/mips_chk_chan.sv
// One checkpoint channel: stored (en, adr, dat) entry plus its hit flag, and
// the per-cycle comparison of the current store against that entry.
module mips_chk_chan
  import mips_dbg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  chan_entry_t       wr_entry,
  input  logic              clr_hit,
  input  logic              set_hit,
  input  logic              eval,
  input  logic [WIDTH-1:0]  dataadr,
  input  logic [WIDTH-1:0]  writedata,
  output logic              en,
  output logic              hit,
  output logic              match_ok,
  output logic              match_bad
);

  logic [MAX_W-1:0] adr_q;
  logic [MAX_W-1:0] dat_q;
  logic             adr_eq;

  always_ff @(posedge clk) begin
    if (wr) begin
      adr_q <= wr_entry.adr;
      dat_q <= wr_entry.dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en  <= 1'b0;
      hit <= 1'b0;
    end else begin
      if (wr)
        en <= wr_entry.en;
      if (clr_hit)
        hit <= 1'b0;
      else if (set_hit)
        hit <= 1'b1;
    end
  end

  // A correct store to an already-hit channel is neither ok nor bad.
  assign adr_eq    = eval && en && (adr_q == MAX_W'(dataadr));
  assign match_ok  = adr_eq && (dat_q == MAX_W'(writedata)) && !hit;
  assign match_bad = adr_eq && (dat_q != MAX_W'(writedata));

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor for the single-cycle MIPS: checks data-memory stores against a
// checkpoint table and produces a registered pass/mismatch/timeout verdict.
module mips_run_monitor
  import mips_dbg_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 4,
  parameter  int TIMEOUT  = 1024,
  parameter  int ORDERED  = 0,
  localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CYC_W    = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memwrite,
  input  logic [WIDTH-1:0]    dataadr,
  input  logic [WIDTH-1:0]    writedata,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic                cfg_en,
  input  logic [WIDTH-1:0]    cfg_adr,
  input  logic [WIDTH-1:0]    cfg_dat,
  input  logic                arm,
  output logic                done,
  output logic [1:0]          status,
  output logic [IDX_W-1:0]    fail_chan,
  output logic [CHANNELS-1:0] hit_mask,
  output logic [CYC_W-1:0]    cycles
);

  state_t            state_q, state_d;
  logic [1:0]        status_d;
  logic [IDX_W-1:0]  fail_chan_d;
  logic              done_d;

  logic [CHANNELS-1:0] en_v, hit_v, raw_ok, raw_bad, order_bad, ok_v, bad_v;
  logic              cfg_ok, eval, pending, any_bad, all_hit, timeout_hit;
  logic [IDX_W-1:0]  bad_idx;
  chan_entry_t       wr_entry;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [CHANNELS-1:0] v);
    lowest_idx = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (v[c])
        lowest_idx = IDX_W'(c);
  endfunction

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    sat_inc = (v == CYC_W'(TIMEOUT)) ? v : v + 1'b1;
  endfunction

  // arm wins over configuration and store evaluation in the same cycle.
  assign cfg_ok   = (state_q == ST_IDLE) && cfg_we && !arm;
  assign eval     = (state_q == ST_ARMED) && memwrite && !arm;
  assign wr_entry = '{en: cfg_en, adr: MAX_W'(cfg_adr), dat: MAX_W'(cfg_dat)};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    mips_chk_chan #(.WIDTH(WIDTH)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .wr        (cfg_ok && (cfg_idx == IDX_W'(c))),
      .wr_entry  (wr_entry),
      .clr_hit   (arm),
      .set_hit   (ok_v[c]),
      .eval      (eval),
      .dataadr   (dataadr),
      .writedata (writedata),
      .en        (en_v[c]),
      .hit       (hit_v[c]),
      .match_ok  (raw_ok[c]),
      .match_bad (raw_bad[c])
    );
  end

  // Ordered mode: a lower enabled channel still unsatisfied (including hits
  // landing this cycle) turns a correct hit into a mismatch.
  always_comb begin
    order_bad = '0;
    pending   = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((ORDERED != 0) && raw_ok[c] && pending)
        order_bad[c] = 1'b1;
      if (en_v[c] && !hit_v[c] && !raw_ok[c])
        pending = 1'b1;
    end
  end

  assign ok_v        = raw_ok & ~order_bad;
  assign bad_v       = raw_bad | order_bad;
  assign any_bad     = |bad_v;
  assign bad_idx     = lowest_idx(bad_v);
  assign all_hit     = ((hit_v | ok_v) & en_v) == en_v;
  assign timeout_hit = (cycles == CYC_W'(TIMEOUT - 1));
  assign hit_mask    = hit_v;

  always_comb begin
    state_d     = state_q;
    status_d    = status;
    fail_chan_d = fail_chan;
    done_d      = done;
    if (arm) begin
      state_d     = ST_ARMED;
      status_d    = STAT_RUN;
      fail_chan_d = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (any_bad) begin
            state_d     = ST_FAIL;
            status_d    = STAT_MISMATCH;
            fail_chan_d = bad_idx;
            done_d      = 1'b1;
          end else if (all_hit) begin
            state_d  = ST_PASS;
            status_d = STAT_PASS;
            done_d   = 1'b1;
          end else if (timeout_hit) begin
            state_d  = ST_FAIL;
            status_d = STAT_TIMEOUT;
            done_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      status    <= STAT_RUN;
      fail_chan <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      status    <= status_d;
      fail_chan <= fail_chan_d;
      done      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || arm)
      cycles <= '0;
    else if (state_q == ST_ARMED)
      cycles <= sat_inc(cycles);
  end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: two instances (default and TIMEOUT=16/ORDERED=1)
// share stimulus and are compared every cycle against a behavioural model.
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0;
  logic        cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_adr = '0, cfg_dat = '0;
  logic        arm = 1'b0;

  logic        done_a, done_b;
  logic [1:0]  status_a, status_b, fail_a, fail_b;
  logic [3:0]  hit_a, hit_b;
  logic [10:0] cyc_a;
  logic [4:0]  cyc_b;

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  mips_run_monitor u_a (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_adr(cfg_adr), .cfg_dat(cfg_dat), .arm(arm), .done(done_a),
    .status(status_a), .fail_chan(fail_a), .hit_mask(hit_a), .cycles(cyc_a)
  );

  mips_run_monitor #(.TIMEOUT(16), .ORDERED(1)) u_b (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_adr(cfg_adr), .cfg_dat(cfg_dat), .arm(arm), .done(done_b),
    .status(status_b), .fail_chan(fail_b), .hit_mask(hit_b), .cycles(cyc_b)
  );

  // Reference model; phase 0 idle, 1 running, 2 passed, 3 failed.
  int          tmo[2] = '{1024, 16};
  int          ord[2] = '{0, 1};
  int          m_phase[2], m_cyc[2], m_status[2], m_fchan[2];
  bit          m_en[2][4];
  logic [31:0] m_adr[2][4], m_dat[2][4];
  bit   [3:0]  m_hit[2];
  bit          m_done[2];

  function automatic void model_step();
    bit [3:0] ok, bad;
    int old;
    bit allhit;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        m_phase[m] = 0; m_hit[m] = '0; m_cyc[m] = 0; m_status[m] = 0; m_fchan[m] = 0;
        for (int c = 0; c < 4; c++) m_en[m][c] = 1'b0;
      end else if (arm) begin
        m_phase[m] = 1; m_hit[m] = '0; m_cyc[m] = 0; m_status[m] = 0; m_fchan[m] = 0;
      end else if (m_phase[m] == 0) begin
        if (cfg_we) begin
          m_en[m][cfg_idx] = cfg_en; m_adr[m][cfg_idx] = cfg_adr; m_dat[m][cfg_idx] = cfg_dat;
        end
      end else if (m_phase[m] == 1) begin
        ok = '0; bad = '0;
        for (int c = 0; c < 4; c++)
          if (memwrite && m_en[m][c] && dataadr == m_adr[m][c]) begin
            if (writedata != m_dat[m][c]) bad[c] = 1'b1;
            else if (!m_hit[m][c]) ok[c] = 1'b1;
          end
        if (ord[m] != 0)
          for (int c = 0; c < 4; c++)
            if (ok[c])
              for (int j = 0; j < c; j++)
                if (m_en[m][j] && !m_hit[m][j] && !ok[j]) bad[c] = 1'b1;
        ok = ok & ~bad;
        old = m_cyc[m];
        m_cyc[m] = (old + 1 > tmo[m]) ? tmo[m] : old + 1;
        m_hit[m] = m_hit[m] | ok;
        allhit = 1'b1;
        for (int c = 0; c < 4; c++) if (m_en[m][c] && !m_hit[m][c]) allhit = 1'b0;
        if (bad != 0) begin
          m_phase[m] = 3; m_status[m] = 2;
          for (int c = 3; c >= 0; c--) if (bad[c]) m_fchan[m] = c;
        end else if (allhit) begin
          m_phase[m] = 2; m_status[m] = 1;
        end else if (old == tmo[m] - 1) begin
          m_phase[m] = 3; m_status[m] = 3;
        end
      end
      m_done[m] = (m_phase[m] >= 2);
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a_done"},   done_a,   m_done[0]);
    chk({tag, "_a_status"}, status_a, m_status[0]);
    chk({tag, "_a_fchan"},  fail_a,   m_fchan[0]);
    chk({tag, "_a_hit"},    hit_a,    m_hit[0]);
    chk({tag, "_a_cycles"}, cyc_a,    m_cyc[0]);
    chk({tag, "_b_done"},   done_b,   m_done[1]);
    chk({tag, "_b_status"}, status_b, m_status[1]);
    chk({tag, "_b_fchan"},  fail_b,   m_fchan[1]);
    chk({tag, "_b_hit"},    hit_b,    m_hit[1]);
    chk({tag, "_b_cycles"}, cyc_b,    m_cyc[1]);
  endtask

  string phase = "init";

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all(phase);
    reset = 1'b0; arm = 1'b0; cfg_we = 1'b0; memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step();
  endtask

  task automatic do_arm();
    arm = 1'b1; step();
  endtask

  task automatic do_cfg(input int idx, input bit en, input logic [31:0] adr, input logic [31:0] dat);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en; cfg_adr = adr; cfg_dat = dat;
    step();
  endtask

  task automatic do_store(input logic [31:0] adr, input logic [31:0] dat);
    memwrite = 1'b1; dataadr = adr; writedata = dat;
    step();
  endtask

  initial begin
    phase = "reset";
    do_reset(); do_reset();
    chk("rst_done", done_a, 1'b0);
    chk("rst_status", status_a, 2'b00);
    chk("rst_cycles", cyc_a, 0);

    phase = "single";
    do_cfg(0, 1, 32'h54, 7);
    do_arm();
    idle(9);
    do_store(32'h54, 7);
    chk("t1_done", done_a, 1'b1);
    chk("t1_status", status_a, 2'b01);
    chk("t1_hit", hit_a, 4'b0001);
    chk("t1_cycles", cyc_a, 10);

    phase = "mismatch";
    do_reset();
    do_cfg(0, 1, 32'h54, 7);
    do_cfg(1, 1, 32'h58, 24);
    do_arm();
    do_store(32'h58, 25);
    chk("t2_status", status_a, 2'b10);
    chk("t2_fchan", fail_a, 2'd1);
    chk("t2_done", done_a, 1'b1);
    do_store(32'h54, 7);
    do_store(32'h58, 24);
    idle(2);
    chk("t2_hold_status", status_a, 2'b10);
    chk("t2_hold_hit", hit_a, 4'b0000);
    chk("t2_hold_cycles", cyc_a, 1);

    phase = "timeout";
    do_reset();
    do_cfg(0, 1, 32'h60, 5);
    do_arm();
    idle(15);
    chk("t3_not_yet", done_b, 1'b0);
    idle(1);
    chk("t3_done", done_b, 1'b1);
    chk("t3_status", status_b, 2'b11);
    chk("t3_cycles", cyc_b, 16);
    do_reset();
    do_cfg(0, 1, 32'h60, 5);
    do_arm();
    idle(15);
    do_store(32'h60, 5);
    chk("t3_last_status", status_b, 2'b01);

    phase = "timeout_a";
    do_reset();
    do_cfg(0, 1, 32'h60, 5);
    do_arm();
    idle(1023);
    chk("t3a_not_yet", done_a, 1'b0);
    idle(1);
    chk("t3a_status", status_a, 2'b11);
    idle(3);
    chk("t3a_sat", cyc_a, 1024);

    phase = "ordered";
    do_reset();
    do_cfg(0, 1, 32'h50, 1);
    do_cfg(1, 1, 32'h54, 2);
    do_arm();
    do_store(32'h54, 2);
    chk("t4_status", status_b, 2'b10);
    chk("t4_fchan", fail_b, 2'd1);
    chk("t4_unord_hit", hit_a, 4'b0010);
    do_store(32'h50, 1);
    chk("t4_unord_pass", status_a, 2'b01);
    do_reset();
    do_cfg(0, 1, 32'h50, 1);
    do_cfg(1, 1, 32'h54, 2);
    do_arm();
    do_store(32'h50, 1);
    do_store(32'h54, 2);
    chk("t4_inorder", status_b, 2'b01);
    chk("t4_inorder_hit", hit_b, 4'b0011);

    phase = "midrun";
    do_reset();
    do_cfg(0, 1, 32'h54, 7);
    do_arm();
    idle(3);
    do_reset();
    chk("t5_rst_cycles", cyc_a, 0);
    chk("t5_rst_done", done_a, 1'b0);
    do_arm();
    idle(1);
    chk("t5_empty_table", status_a, 2'b01);
    do_reset();
    do_cfg(0, 1, 32'h54, 7);
    do_arm();
    do_cfg(0, 1, 32'h54, 9);
    do_store(32'h54, 7);
    chk("t5_cfg_ignored", status_a, 2'b01);
    do_arm();
    chk("t5_rearm_hit", hit_a, 4'b0000);
    chk("t5_rearm_cycles", cyc_a, 0);
    chk("t5_rearm_status", status_a, 2'b00);

    phase = "nochan";
    do_reset();
    do_arm();
    chk("t6_armed", done_a, 1'b0);
    idle(1);
    chk("t6_pass", status_a, 2'b01);
    chk("t6_cycles", cyc_a, 1);

    phase = "random";
    for (int run = 0; run < 30; run++) begin
      do_reset();
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) != 0)
          do_cfg(c, 1'($urandom_range(0, 1)), 32'h40 + 4 * $urandom_range(0, 3),
                 32'($urandom_range(0, 3)));
      do_arm();
      for (int i = 0; i < 40; i++) begin
        memwrite  = 1'($urandom_range(0, 1));
        dataadr   = 32'h40 + 4 * $urandom_range(0, 3);
        writedata = 32'($urandom_range(0, 3));
        cfg_we    = ($urandom_range(0, 7) == 0);
        cfg_idx   = 2'($urandom_range(0, 3));
        cfg_en    = 1'b1;
        cfg_adr   = 32'h40 + 4 * $urandom_range(0, 3);
        cfg_dat   = 32'($urandom_range(0, 3));
        arm       = ($urandom_range(0, 31) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
